// File: rtl/eaglesong_search_pkg.sv
// Shared types and byte-layout constants for the eaglesong nonce search controller.
package eaglesong_search_pkg;

  localparam int unsigned PREFIX_BYTES     = 24;
  localparam int unsigned NONCE_BYTES      = 8;
  localparam int unsigned DIGEST_LEN_BYTES = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CHECK,
    REPORT,
    ADVANCE,
    FINISH
  } state_t;

endpackage

// File: rtl/eaglesong_target_compare.sv
// Combinational target check: the digest is read big-endian (byte 0 = bits [7:0] is the MSB)
// and compared unsigned against the target.
module eaglesong_target_compare
  import eaglesong_search_pkg::*;
(
  input  logic [DIGEST_LEN_BYTES*8-1:0] digest,
  input  logic [255:0]                  target,
  output logic                          hit
);

  logic [DIGEST_LEN_BYTES*8-1:0] digest_be;

  always_comb begin
    digest_be = '0;
    for (int unsigned i = 0; i < DIGEST_LEN_BYTES; i++) begin
      digest_be[DIGEST_LEN_BYTES*8-1-8*i -: 8] = digest[8*i +: 8];
    end
    hit = (digest_be <= target);
  end

endmodule

// File: rtl/eaglesong_nonce_search.sv
// Job controller that walks a nonce range through eaglesong_digest_top and reports target hits.
// Optional WAIT watchdog and timeout_err port: define EAGLESONG_SEARCH_TIMEOUT_EN.
module eaglesong_nonce_search
  import eaglesong_search_pkg::*;
#(
  parameter logic        STOP_ON_FIRST  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [PREFIX_BYTES*8-1:0]     job_prefix,
  input  logic [NONCE_BYTES*8-1:0]      job_nonce_start,
  input  logic [31:0]                   job_nonce_count,
  input  logic [255:0]                  job_target,
  input  logic                          abort,
  output logic [DIGEST_LEN_BYTES*8-1:0] dig_input_val,
  output logic [6:0]                    dig_input_length_bytes,
  output logic                          dig_start_eval,
  input  logic [DIGEST_LEN_BYTES*8-1:0] dig_output_val,
  input  logic                          dig_eval_output_ready,
  output logic                          found_valid,
  input  logic                          found_ready,
  output logic [NONCE_BYTES*8-1:0]      found_nonce,
  output logic [DIGEST_LEN_BYTES*8-1:0] found_digest,
  output logic                          busy,
  output logic                          done,
  output logic                          exhausted,
  output logic [31:0]                   hash_count
`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  state_t                        state;
  logic [PREFIX_BYTES*8-1:0]     prefix_q;
  logic [NONCE_BYTES*8-1:0]      nonce_q;
  logic [31:0]                   remaining_q;
  logic [255:0]                  target_q;
  logic [DIGEST_LEN_BYTES*8-1:0] digest_q;
  logic                          abort_pend;
  logic                          hit_done;
  logic                          hit;
`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
  logic [31:0]                   wait_cnt;
`endif

  assign dig_input_length_bytes = 7'(DIGEST_LEN_BYTES);

  eaglesong_target_compare u_cmp (
    .digest (digest_q),
    .target (target_q),
    .hit    (hit)
  );

  // Outputs are assigned on the transition into the state they belong to, so they are
  // registered and line up exactly with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      job_ready      <= 1'b0;
      busy           <= 1'b0;
      dig_start_eval <= 1'b0;
      dig_input_val  <= '0;
      found_valid    <= 1'b0;
      found_nonce    <= '0;
      found_digest   <= '0;
      done           <= 1'b0;
      exhausted      <= 1'b0;
      hash_count     <= '0;
      prefix_q       <= '0;
      nonce_q        <= '0;
      remaining_q    <= '0;
      target_q       <= '0;
      digest_q       <= '0;
      abort_pend     <= 1'b0;
      hit_done       <= 1'b0;
`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      dig_start_eval <= 1'b0;
      done           <= 1'b0;
      exhausted      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            prefix_q    <= job_prefix;
            nonce_q     <= job_nonce_start;
            remaining_q <= job_nonce_count;
            target_q    <= job_target;
            hash_count  <= '0;
            hit_done    <= 1'b0;
            abort_pend  <= 1'b0;
            job_ready   <= 1'b0;
            busy        <= 1'b1;
`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            if (job_nonce_count == '0) begin
              state     <= FINISH;
              done      <= 1'b1;
              exhausted <= 1'b1;
            end else begin
              state          <= LAUNCH;
              dig_start_eval <= 1'b1;
              dig_input_val  <= {job_nonce_start, job_prefix};
            end
          end else if (abort) begin
            state     <= FINISH;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b1;
            exhausted <= 1'b1;
          end else begin
            job_ready <= 1'b1;
          end
        end
        LAUNCH: begin
          // The start pulse is already out, so an abort here must still drain WAIT.
          state <= WAIT;
          if (abort) abort_pend <= 1'b1;
`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (dig_eval_output_ready) begin
            hash_count <= hash_count + 32'd1;
            digest_q   <= dig_output_val;
            if (abort_pend || abort) begin
              state     <= FINISH;
              done      <= 1'b1;
              exhausted <= !hit_done;
            end else begin
              state <= CHECK;
            end
          end
`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
          else if (wait_cnt >= TIMEOUT_CYCLES - 1) begin
            state       <= FINISH;
            done        <= 1'b1;
            exhausted   <= 1'b1;
            timeout_err <= 1'b1;
          end
`endif
          else begin
            if (abort) abort_pend <= 1'b1;
`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
            wait_cnt <= wait_cnt + 32'd1;
`endif
          end
        end
        CHECK: begin
          if (abort) begin
            state     <= FINISH;
            done      <= 1'b1;
            exhausted <= !hit_done;
          end else if (hit) begin
            state        <= REPORT;
            found_valid  <= 1'b1;
            found_nonce  <= nonce_q;
            found_digest <= digest_q;
          end else begin
            state <= ADVANCE;
          end
        end
        REPORT: begin
          if (abort) begin
            state       <= FINISH;
            found_valid <= 1'b0;
            done        <= 1'b1;
            exhausted   <= !hit_done;
          end else if (found_ready) begin
            found_valid <= 1'b0;
            hit_done    <= 1'b1;
            if (STOP_ON_FIRST) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= ADVANCE;
            end
          end
        end
        ADVANCE: begin
          nonce_q     <= nonce_q + 64'd1;
          remaining_q <= remaining_q - 32'd1;
          if (abort || remaining_q == 32'd1) begin
            state     <= FINISH;
            done      <= 1'b1;
            exhausted <= !hit_done;
          end else begin
            state          <= LAUNCH;
            dig_start_eval <= 1'b1;
            dig_input_val  <= {nonce_q + 64'd1, prefix_q};
          end
        end
        FINISH: begin
          state     <= IDLE;
          busy      <= 1'b0;
          job_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
